// File: rtl/instmem_loader_pkg.sv
// rtl/instmem_loader_pkg.sv - shared constants and loader state encoding
package instmem_loader_pkg;

  localparam int MEM_DEPTH    = 2048;
  localparam int ISR_DEPTH    = 2048;
  localparam int MEM_WIDTH    = 16;
  localparam int PC_ADDR_BITS = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV_LO = 2'd1,
    RECV_HI = 2'd2,
    FINISH  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instmem_loader_byte_packer.sv
// rtl/instmem_loader_byte_packer.sv - byte handshake and little-endian halfword assembly
module instmem_loader_byte_packer
  import instmem_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  loader_state_t state,
  input  logic [7:0]    byte_data,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          lo_taken,
  output logic          hw_valid,
  output logic [15:0]   hw_data
);

  logic [7:0] lo_byte;
  logic       xfer;

  assign byte_ready = (state == RECV_LO) || (state == RECV_HI);
  assign xfer       = byte_valid && byte_ready;
  assign lo_taken   = xfer && (state == RECV_LO);
  assign hw_valid   = xfer && (state == RECV_HI);
  // High byte goes straight through so the write can be registered on this edge.
  assign hw_data    = {byte_data, lo_byte};

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte <= 8'h00;
    end else if (lo_taken) begin
      lo_byte <= byte_data;
    end
  end

endmodule

// File: rtl/instmem_loader.sv
// rtl/instmem_loader.sv - byte-stream downloader into main or ISR instruction memory
module instmem_loader
  import instmem_loader_pkg::*;
#(
  parameter int ADDR_BITS = PC_ADDR_BITS,
  parameter int HW_WIDTH  = MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 load_isr,
  input  logic [ADDR_BITS-1:0] load_base,
  input  logic [ADDR_BITS:0]   load_len,
  input  logic [7:0]           byte_data,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 wr_en_prog,
  output logic                 wr_en_isr,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [HW_WIDTH-1:0]  wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          checksum
);

  localparam logic [ADDR_BITS+1:0] LIMIT = (ADDR_BITS+2)'(1) << ADDR_BITS;

  loader_state_t          state, next_state;
  logic                   target_isr;
  logic [ADDR_BITS-1:0]   base;
  logic [ADDR_BITS:0]     len;
  logic [ADDR_BITS:0]     count;
  logic [ADDR_BITS:0]     count_inc;
  logic [ADDR_BITS+1:0]   end_addr;
  logic                   over;
  logic                   accept;
  logic                   reject;
  logic                   lo_taken;
  logic                   hw_valid;
  logic [15:0]            hw_data;

  instmem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .lo_taken   (lo_taken),
    .hw_valid   (hw_valid),
    .hw_data    (hw_data)
  );

  // Computed two bits wider than an address so base + len cannot wrap.
  assign end_addr  = {2'b00, load_base} + {1'b0, load_len};
  assign over      = end_addr > LIMIT;
  assign count_inc = count + {{ADDR_BITS{1'b0}}, 1'b1};

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          if (over) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = (load_len == '0) ? FINISH : RECV_LO;
          end
        end
      end
      RECV_LO: if (lo_taken) next_state = RECV_HI;
      RECV_HI: if (hw_valid) next_state = (count_inc == len) ? FINISH : RECV_LO;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target_isr <= 1'b0;
      base       <= '0;
      len        <= '0;
      count      <= '0;
      checksum   <= 16'h0000;
      wr_en_prog <= 1'b0;
      wr_en_isr  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      error      <= reject;
      wr_en_prog <= 1'b0;
      wr_en_isr  <= 1'b0;
      if (accept) begin
        target_isr <= load_isr;
        base       <= load_base;
        len        <= load_len;
        count      <= '0;
        checksum   <= 16'h0000;
      end
      if (hw_valid) begin
        wr_data    <= hw_data;
        wr_addr    <= base + count[ADDR_BITS-1:0];
        wr_en_isr  <= target_isr;
        wr_en_prog <= !target_isr;
        checksum   <= checksum + hw_data;
        count      <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_instmem_loader.sv
// tb/tb_instmem_loader.sv - scoreboard bench for instmem_loader
module tb_instmem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_isr = 1'b0;
  logic [10:0] load_base = '0;
  logic [11:0] load_len = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en_prog, wr_en_isr;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy, done, error;
  logic [15:0] checksum;

  instmem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_isr(load_isr),
    .load_base(load_base), .load_len(load_len), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en_prog(wr_en_prog),
    .wr_en_isr(wr_en_isr), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;
  typedef struct {
    int          kind;
    logic        isr;
    logic [10:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic isr, input logic [10:0] addr, input logic [15:0] data);
    ev_t e;
    e.kind = kind; e.isr = isr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic isr, input logic [10:0] addr, input logic [15:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d isr %0d addr %0h data %0h, expected none", kind, isr, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_WR && (e.isr !== isr || e.addr !== addr || e.data !== data))) begin
        errors++;
        $display("FAIL event: got kind %0d isr %0d addr %0h data %0h, expected kind %0d isr %0d addr %0h data %0h",
                 kind, isr, addr, data, e.kind, e.isr, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_prog && wr_en_isr) begin
        checks++;
        errors++;
        $display("FAIL both_strobes: got prog=1 isr=1 expected one-hot");
      end
      if (wr_en_prog || wr_en_isr) pop_cmp(K_WR, wr_en_isr, wr_addr, wr_data);
      if (done) pop_cmp(K_DONE, 1'b0, '0, '0);
      if (error) pop_cmp(K_ERR, 1'b0, '0, '0);
    end
  end

  task automatic do_start(input logic isr, input logic [10:0] base, input logic [11:0] len);
    load_start = 1'b1; load_isr = isr; load_base = base; load_len = len;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send(input int stall);
    logic [7:0] b;
    int n;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      if (stall > 0) begin
        byte_valid = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
      end
      byte_valid = 1'b1; byte_data = b; n = 0;
      while (!byte_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (n == 20) begin
        checks++; errors++;
        $display("FAIL byte_ready_timeout: got ready=0 expected ready=1");
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] sum;
    logic [7:0]  lo, hi;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_ready", byte_ready, 0);
    chk("reset_strobes", {wr_en_prog, wr_en_isr}, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_checksum", checksum, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic main-memory load
    push_ev(K_WR, 1'b0, 11'h000, 16'h0013);
    push_ev(K_WR, 1'b0, 11'h001, 16'h0093);
    push_ev(K_DONE, 1'b0, '0, '0);
    do_start(1'b0, 11'h000, 12'd2);
    chk("basic_busy", busy, 1);
    chk("basic_ready", byte_ready, 1);
    tx_q = '{8'h13, 8'h00, 8'h93, 8'h00};
    send(0);
    chk("basic_done_with_strobe", {done, wr_en_prog}, 2'b11);
    @(posedge clk); #1;
    chk("basic_busy_fall", busy, 0);
    chk("basic_checksum", checksum, 16'h00A6);

    // ISR target at the top of memory with stalls
    push_ev(K_WR, 1'b1, 11'h7FE, 16'h2211);
    push_ev(K_WR, 1'b1, 11'h7FF, 16'h4433);
    push_ev(K_DONE, 1'b0, '0, '0);
    do_start(1'b1, 11'h7FE, 12'd2);
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(2);
    @(posedge clk); #1;
    chk("isr_checksum", checksum, 16'h6644);

    // Out of bounds request
    push_ev(K_ERR, 1'b0, '0, '0);
    do_start(1'b0, 11'h7FF, 12'd2);
    chk("bounds_error", error, 1);
    chk("bounds_busy", busy, 0);
    @(posedge clk); #1;
    chk("bounds_error_pulse", error, 0);
    chk("bounds_checksum_held", checksum, 16'h6644);

    // Zero length
    push_ev(K_DONE, 1'b0, '0, '0);
    do_start(1'b0, 11'h005, 12'd0);
    chk("zero_done", done, 1);
    @(posedge clk); #1;
    chk("zero_checksum", checksum, 0);
    chk("zero_busy", busy, 0);

    // Full-depth load
    sum = 16'h0000;
    for (int i = 0; i < 2048; i++) begin
      lo = i[7:0];
      hi = i[10:3] ^ 8'h3C;
      tx_q.push_back(lo);
      tx_q.push_back(hi);
      push_ev(K_WR, 1'b0, i[10:0], {hi, lo});
      sum = sum + {hi, lo};
    end
    push_ev(K_DONE, 1'b0, '0, '0);
    do_start(1'b0, 11'h000, 12'h800);
    chk("full_busy", busy, 1);
    send(0);
    @(posedge clk); #1;
    chk("full_checksum", checksum, sum);

    // Reset in the middle of a download
    push_ev(K_WR, 1'b0, 11'h010, 16'h2211);
    do_start(1'b0, 11'h010, 12'd2);
    tx_q = '{8'h11, 8'h22, 8'h33};
    send(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", byte_ready, 0);
    chk("rst_mid_outputs", {wr_en_prog, wr_en_isr, done, error, wr_addr, wr_data, checksum}, 0);
    push_ev(K_WR, 1'b0, 11'h020, 16'hCDAB);
    push_ev(K_DONE, 1'b0, '0, '0);
    do_start(1'b0, 11'h020, 12'd1);
    tx_q = '{8'hAB, 8'hCD};
    send(0);
    @(posedge clk); #1;
    chk("after_rst_checksum", checksum, 16'hCDAB);

    // Start request while busy is ignored
    push_ev(K_WR, 1'b1, 11'h100, 16'h0201);
    push_ev(K_WR, 1'b1, 11'h101, 16'h0403);
    push_ev(K_DONE, 1'b0, '0, '0);
    do_start(1'b1, 11'h100, 12'd2);
    tx_q = '{8'h01, 8'h02, 8'h03};
    send(0);
    do_start(1'b0, 11'h300, 12'd5);
    chk("busy_start_no_error", error, 0);
    tx_q = '{8'h04};
    send(0);
    @(posedge clk); #1;
    chk("busy_start_checksum", checksum, 16'h0604);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
